// File: rtl/case_demux_pkg.sv
// Shared types, lane select codes and the lane decode used by the demux router.
package case_demux_pkg;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE0 = 2'b00;
    localparam lane_t LANE1 = 2'b01;
    localparam lane_t LANE2 = 2'b10;
    localparam lane_t LANE3 = 2'b11;

    localparam int NUM_LANES = 4;

    // Map a select code to a lane index. Any code that is not explicitly
    // listed falls through to lane 1, so that lane is the catch-all.
    function automatic lane_t decode_lane(input lane_t sel);
        lane_t lane;
        case (sel)
            LANE0:   lane = 2'd0;
            LANE2:   lane = 2'd2;
            LANE3:   lane = 2'd3;
            default: lane = 2'd1;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/case_demux_lane.sv
// One-entry holding register with a full flag for a single output lane.
// A load and a drain in the same cycle keep the lane full with the new word.
module case_demux_lane
    import case_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Space is available when empty, or when the current word leaves this cycle.
    assign can_load  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Next-state for the full flag and the holding register.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (out_ready) begin
            full_d = 1'b0;
        end
    end

    // Lane state flops; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/case_demux_router.sv
// 1-to-4 demultiplexing router: decodes the lane select, steers the accepted
// word into that lane's holding register and counts accepted words.
module case_demux_router
    import case_demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_sel,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [W-1:0]     out_data0,
    output logic [W-1:0]     out_data1,
    output logic [W-1:0]     out_data2,
    output logic [W-1:0]     out_data3,
    output logic [CNT_W-1:0] xfer_count
);

    lane_t                lane_sel;
    logic                 accept;
    logic [NUM_LANES-1:0] can_load;
    logic [NUM_LANES-1:0] load;
    logic [W-1:0]         lane_data [NUM_LANES];
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    assign lane_sel = decode_lane(in_sel);

    // Readiness depends only on the addressed lane, so a stalled lane never
    // blocks words headed elsewhere.
    assign in_ready = can_load[lane_sel];
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign load[gi] = accept && (lane_sel == lane_t'(gi));

            case_demux_lane #(.W(W)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .load      (load[gi]),
                .load_data (in_data),
                .out_ready (out_ready[gi]),
                .out_valid (out_valid[gi]),
                .out_data  (lane_data[gi]),
                .can_load  (can_load[gi])
            );
        end
    endgenerate

    assign out_data0  = lane_data[0];
    assign out_data1  = lane_data[1];
    assign out_data2  = lane_data[2];
    assign out_data3  = lane_data[3];
    assign xfer_count = count_q;

    // Accepted-word counter; wraps naturally at 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_case_demux_router.sv
// Directed bench for case_demux_router with hand-computed expectations.
module tb_case_demux_router;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       in_sel;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [W-1:0]     out_data0;
    logic [W-1:0]     out_data1;
    logic [W-1:0]     out_data2;
    logic [W-1:0]     out_data3;
    logic [CNT_W-1:0] xfer_count;

    int errors = 0;
    int checks = 0;

    case_demux_router #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_out(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        out_ready = 4'b0000;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_count", 32'(xfer_count), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        $display("reset released");

        // One word per lane, all consumers ready.
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 4'hA + 4'(k);
            step();
            check($sformatf("onehot_valid_%0d", k), 32'(out_valid), 32'(4'b0001 << k));
            check($sformatf("lane_data_%0d", k), 32'(lane_out(k)), 32'(4'hA + 4'(k)));
            $display("sel=%0d data=%0h -> out_valid=%b", k, 4'hA + 4'(k), out_valid);
        end
        in_valid = 1'b0;
        step();
        check("count_after_four", 32'(xfer_count), 32'd4);
        check("all_drained", 32'(out_valid), 32'h0);

        // Lane 1 backpressure.
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'b01;
        in_data   = 4'h1;
        step();
        check("l1_first_valid", 32'(out_valid[1]), 32'h1);
        check("l1_first_data", 32'(out_data1), 32'h1);
        in_data = 4'h2;
        #1;
        check("l1_blocked_ready", 32'(in_ready), 32'h0);
        step();
        check("l1_held_data", 32'(out_data1), 32'h1);
        check("l1_held_count", 32'(xfer_count), 32'd5);
        out_ready = 4'b1111;
        #1;
        check("l1_passthru_ready", 32'(in_ready), 32'h1);
        step();
        check("l1_second_valid", 32'(out_valid[1]), 32'h1);
        check("l1_second_data", 32'(out_data1), 32'h2);
        check("l1_count", 32'(xfer_count), 32'd6);
        $display("lane1 stall/release done count=%0d", xfer_count);
        in_valid = 1'b0;
        step();

        // Lane 3 stalled, other lanes still flow.
        out_ready = 4'b0111;
        in_valid  = 1'b1;
        in_sel    = 2'b11;
        in_data   = 4'h7;
        step();
        check("l3_loaded", 32'(out_data3), 32'h7);
        in_data = 4'h8;
        #1;
        check("l3_blocked_ready", 32'(in_ready), 32'h0);
        step();
        check("l3_unchanged", 32'(out_data3), 32'h7);
        in_sel  = 2'b00;
        in_data = 4'h5;
        #1;
        check("l0_ready_while_l3_stall", 32'(in_ready), 32'h1);
        step();
        check("l0_bypass_data", 32'(out_data0), 32'h5);
        check("l0_l3_valid", 32'(out_valid), 32'b1001);
        check("l3_data_kept", 32'(out_data3), 32'h7);
        check("l3_count", 32'(xfer_count), 32'd8);
        $display("lane3 stall, lane0 word=5 delivered");

        // Back-to-back drain and accept on lane 0.
        for (int d = 0; d < 16; d++) begin
            in_sel  = 2'b00;
            in_data = 4'(d);
            step();
            check($sformatf("stream_valid_%0d", d), 32'(out_valid[0]), 32'h1);
            check($sformatf("stream_data_%0d", d), 32'(out_data0), 32'(d));
        end
        check("stream_count", 32'(xfer_count), 32'd24);
        $display("lane0 stream of 16 done count=%0d", xfer_count);

        // Fill lane 2, then reset mid-cycle.
        out_ready = 4'b1011;
        in_sel    = 2'b10;
        in_data   = 4'hC;
        step();
        in_valid = 1'b0;
        check("l2_full_pre_reset", 32'(out_valid[2]), 32'h1);
        check("l2_data_pre_reset", 32'(out_data2), 32'hC);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_data2", 32'(out_data2), 32'h0);
        check("async_count", 32'(xfer_count), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'h1);
        $display("async reset mid-cycle applied");
        step();
        rst = 1'b0;

        // 257 continuous accepts wrap the 8-bit counter to 1.
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_sel  = 2'(i % 4);
            in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        check("wrap_count", 32'(xfer_count), 32'd1);
        check("wrap_last_data", 32'(out_data0), 32'h0);
        $display("257 accepts done count=%0d", xfer_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/case_demux_router.md
Name: case_demux_router

Overview:
- 1-to-4 demultiplexing router with valid/ready handshakes; the distribution end of the 4:1 select datapath.
- Takes a single W-bit input stream tagged with a 2-bit lane select. Delivers each word into one of four output lanes, each backed by a one-entry holding register.
- Sits between a single producer and four independent consumers. Provides backpressure per lane and keeps a wrapping count of delivered words.

Parameters:
- W, 4, data width of input and every output lane
- CNT_W, 8, width of accepted-word counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  producer has a word
- in_sel  input  2  destination lane code
- in_data  input  W  word
- in_ready  output  1  block accepts word this cycle
- out_valid  output  4  lane i holds a word
- out_ready  input  4  consumer i takes word
- out_data0..out_data3  output  W each  lane holding registers
- xfer_count  output  CNT_W  words accepted since reset, wrapping

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Lane decode (case with default):
  - 2'b00 -> lane 0
  - 2'b10 -> lane 2
  - 2'b11 -> lane 3
  - default (2'b01) -> lane 1
  - Decoded lane is L.
- Lane state: per-lane full flag f[i], with two states:
  - EMPTY -> FULL on accept to lane i.
  - FULL -> EMPTY on out_ready[i] with no same-cycle accept to lane i.
  - FULL stays FULL on out_ready[i] together with an accept to lane i; the register reloads with the new word.
- Output signals:
  - out_valid[i] = f[i].
  - out_data_i changes only on an accept to lane i. It holds its last value while empty.
- Input handshake:
  - in_ready = !f[L] || out_ready[L] (combinational, pass-through on drain).
  - in_ready is independent of in_valid. It may be 1 while in_valid = 0.
- Accept and latency:
  - Accept = in_valid && in_ready.
  - Word is registered at the edge and visible on out_data_L with out_valid[L] = 1 the next cycle. Latency is 1 cycle.
  - No combinational path from in_data to out_data.
- Lane independence: a stalled lane (f = 1, out_ready = 0) blocks only words addressed to it. Other lanes keep draining. No head-of-line bypass: the blocked word stays at the input.
- Producer rule: in_sel and in_data are held stable while in_valid && !in_ready. The block does not check this.
- Consumer side: out_ready[i] asserted while f[i] = 0 has no effect.
- Counter:
  - xfer_count increments by 1 on every accept.
  - Wraps from 2^CNT_W-1 to 0.
  - Draining does not affect it.
- Reset (async, any time):
  - f = 0 and out_valid = 0.
  - out_data0..3 = 0.
  - xfer_count = 0.
  - in_ready = 1 (combinational from f = 0).
  - Words held mid-operation are discarded.
  - First accept allowed on the first rising edge after rst deasserts.
- Simultaneous events:
  - Accept to lane i and drain of lane i in the same cycle: lane stays full with the new word; no bubble.
  - Accept to lane j with drain of lane i (j != i): both take effect.

Decomposition:
- Package case_demux_pkg:
  - typedef lane_t (logic[1:0])
  - constants LANE0..LANE3 sel codes
  - NUM_LANES = 4
  - function decode_lane implementing the default-to-lane-1 case
- Sub-module case_demux_lane:
  - One-entry holding register with full flag.
  - Ports: clk, rst, load, load_data, out_ready, out_valid, out_data, can_load.
  - Instantiated 4 times.
- The top holds the decode, in_ready mux and counter.

Test Plan:
- Reset with rst asserted mid-cycle while lane 2 is full -> out_valid immediately 4'b0000, out_data2 = 0, xfer_count = 0, in_ready = 1.
- Send sel 00/01/10/11 with data 4'hA/B/C/D, out_ready = 4'b1111 -> each word on its lane one cycle later; out_valid one-hot per cycle; xfer_count = 4.
- out_ready[1] = 0, send two words with sel 2'b01 -> first accepted; in_ready = 0 on second; raising out_ready[1] accepts the second the same cycle with lane 1 staying valid.
- Lane 3 stalled with a word to lane 3 pending, then switch producer to sel 00 word 4'h5 -> lane 0 receives 4'h5 next cycle; lane 3 data unchanged.
- Continuous accepts for 257 cycles with CNT_W = 8 -> xfer_count wraps to 1.
- Drain and accept on lane 0 every cycle with data 0..15 -> out_valid[0] stays 1 and out_data0 follows input delayed by 1 cycle, no gaps.
